// File: rtl/video_pkg.sv
// Shared constants and types for the video-to-AXI4-Stream bridge.
package video_pkg;

  localparam int WD_VIDEO_DATA  = 8;
  localparam int WD_CONFIG_INFO = 16;
  localparam int WD_ERR_INFO    = 4;
  localparam int NB_FIFO_DEPTH  = 16;

  localparam int ERR_OVF   = 0;
  localparam int ERR_HLEN  = 1;
  localparam int ERR_TRUNC = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } state_e;

endpackage

// File: rtl/video_sync_fifo.sv
// Single-clock FIFO with registered storage; the head entry is always visible on rd_data_o.
module video_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_rd_s;
  logic             do_wr_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign do_rd_s   = rd_en_i & ~empty_o;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_wr_s   = wr_en_i & (~full_o | do_rd_s);
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr_s) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_rd_s) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr_s, do_rd_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/video_to_axis.sv
// Converts the parallel fsync/vsync/hsync/psync video bus into AXI4-Stream video
// with line-length checking and frame drop on FIFO overflow.
module video_to_axis #(
  parameter int WD_VIDEO_DATA  = video_pkg::WD_VIDEO_DATA,
  parameter int WD_CONFIG_INFO = video_pkg::WD_CONFIG_INFO,
  parameter int WD_ERR_INFO    = video_pkg::WD_ERR_INFO,
  parameter int NB_FIFO_DEPTH  = video_pkg::NB_FIFO_DEPTH
) (
  input  logic                      i_sys_clk,
  input  logic                      i_sys_resetn,
  input  logic                      s_video_src_fsync,
  input  logic                      s_video_src_vsync,
  input  logic                      s_video_src_hsync,
  input  logic                      s_video_src_psync,
  input  logic [WD_VIDEO_DATA-1:0]  s_video_src_vdata,
  input  logic [WD_CONFIG_INFO-1:0] s_cinfo_hsize,
  output logic [WD_VIDEO_DATA-1:0]  m_axis_dst_tdata,
  output logic                      m_axis_dst_tvalid,
  input  logic                      m_axis_dst_tready,
  output logic                      m_axis_dst_tuser,
  output logic                      m_axis_dst_tlast,
  output logic [WD_CONFIG_INFO-1:0] m_vinfo_dst_lines,
  output logic [WD_ERR_INFO-1:0]    m_err_video_info
);
  import video_pkg::*;

  localparam int FW = WD_VIDEO_DATA + 2;

  state_e                    state_q, state_d;
  logic [WD_CONFIG_INFO-1:0] hsize_q, hsize_d;
  logic [WD_CONFIG_INFO-1:0] line_cnt_q, line_cnt_d;
  logic [WD_CONFIG_INFO-1:0] pix_cnt_q, pix_cnt_d;
  logic [WD_CONFIG_INFO-1:0] lines_q, lines_d;
  logic [WD_ERR_INFO-1:0]    err_q, err_d;
  logic                      sof_q, sof_d;
  logic                      pend_vld_q, pend_vld_d;
  logic [WD_VIDEO_DATA-1:0]  pend_data_q, pend_data_d;
  logic                      hsync_q, vsync_q;

  logic                      hs_fall_s, vs_fall_s, active_s, accept_s;
  logic                      line_end_s, trunc_s, push_s, push_last_s;
  logic                      rd_s, full_s, empty_s, ovf_s;
  logic [FW-1:0]             push_word_s, head_s;
  logic [WD_CONFIG_INFO-1:0] pix_inc_s, line_inc_s;

  assign hs_fall_s   = hsync_q & ~s_video_src_hsync;
  assign vs_fall_s   = vsync_q & ~s_video_src_vsync;
  assign active_s    = (state_q == ACTIVE);
  assign accept_s    = active_s & ~s_video_src_fsync & s_video_src_vsync &
                       s_video_src_hsync & s_video_src_psync;
  assign line_end_s  = active_s & ~s_video_src_fsync & pend_vld_q & (hs_fall_s | vs_fall_s);
  assign trunc_s     = active_s & s_video_src_fsync & pend_vld_q;
  assign push_s      = (accept_s & pend_vld_q) | line_end_s | trunc_s;
  assign push_last_s = line_end_s | trunc_s;
  assign push_word_s = {sof_q, push_last_s, pend_data_q};
  assign rd_s        = ~empty_s & m_axis_dst_tready;
  assign ovf_s       = push_s & full_s & ~rd_s;
  assign pix_inc_s   = (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + 1'b1;
  assign line_inc_s  = (&line_cnt_q) ? line_cnt_q : line_cnt_q + 1'b1;

  // Frame FSM, pending pixel, counters and error tracking: next-state logic.
  always_comb begin
    state_d     = state_q;
    hsize_d     = hsize_q;
    line_cnt_d  = line_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    lines_d     = lines_q;
    err_d       = err_q;
    sof_d       = sof_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    if (push_s && !ovf_s) sof_d = 1'b0;
    if (line_end_s) begin
      line_cnt_d = line_inc_s;
      pix_cnt_d  = '0;
      pend_vld_d = 1'b0;
      if (pix_cnt_q != hsize_q) err_d[ERR_HLEN] = 1'b1;
    end
    case (state_q)
      IDLE, DROP, ACTIVE: begin
        if (s_video_src_fsync) begin
          if (trunc_s) err_d[ERR_TRUNC] = 1'b1;
          hsize_d    = s_cinfo_hsize;
          sof_d      = 1'b1;
          line_cnt_d = '0;
          pix_cnt_d  = '0;
          pend_vld_d = 1'b0;
          state_d    = ACTIVE;
        end else if (active_s && vs_fall_s) begin
          lines_d = pend_vld_q ? line_inc_s : line_cnt_q;
          state_d = IDLE;
        end else if (accept_s) begin
          pend_vld_d  = 1'b1;
          pend_data_d = s_video_src_vdata;
          pix_cnt_d   = pix_inc_s;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // Overflow abandons the rest of the frame; the next fsync resynchronises.
    if (ovf_s) begin
      err_d[ERR_OVF] = 1'b1;
      pend_vld_d     = 1'b0;
      state_d        = DROP;
    end
  end

  // State registers.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      state_q     <= IDLE;
      hsize_q     <= '0;
      line_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      lines_q     <= '0;
      err_q       <= '0;
      sof_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hsize_q     <= hsize_d;
      line_cnt_q  <= line_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      lines_q     <= lines_d;
      err_q       <= err_d;
      sof_q       <= sof_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      hsync_q     <= s_video_src_hsync;
      vsync_q     <= s_video_src_vsync;
    end
  end

  video_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (NB_FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (i_sys_clk),
    .rst_n_i   (i_sys_resetn),
    .wr_en_i   (push_s),
    .wr_data_i (push_word_s),
    .rd_en_i   (rd_s),
    .rd_data_o (head_s),
    .full_o    (full_s),
    .empty_o   (empty_s)
  );

  assign m_axis_dst_tvalid = ~empty_s;
  assign m_axis_dst_tuser  = head_s[FW-1];
  assign m_axis_dst_tlast  = head_s[FW-2];
  assign m_axis_dst_tdata  = head_s[WD_VIDEO_DATA-1:0];
  assign m_vinfo_dst_lines = lines_q;
  assign m_err_video_info  = err_q;

endmodule

// File: doc/video_to_axis.md
Name: video_to_axis

Overview:
- Downstream neighbour of the sensor-to-video stage. Consumes its parallel video sync/data bus (fsync/vsync/hsync/psync/vdata) and emits AXI4-Stream video: tuser marks start of frame, tlast marks end of line.
- Contains an internal FIFO that absorbs short tready stalls.
- Checks each line's length against a configured width.
- On FIFO overflow, drops the rest of the frame so the stream resynchronises at the next frame.

Parameters:
- WD_VIDEO_DATA, 8, pixel data width.
- WD_CONFIG_INFO, 16, width of the line-size config and the line/pixel counters.
- WD_ERR_INFO, 4, width of the sticky error vector.
- NB_FIFO_DEPTH, 16, FIFO entries; power of two, at least 4.

Ports:
- i_sys_clk  in  1  single clock for all logic.
- i_sys_resetn  in  1  asynchronous active-low reset.
- s_video_src_fsync  in  1  one-cycle frame-start pulse.
- s_video_src_vsync  in  1  frame-active level.
- s_video_src_hsync  in  1  line-active level.
- s_video_src_psync  in  1  pixel-valid strobe.
- s_video_src_vdata  in  WD_VIDEO_DATA  pixel data.
- s_cinfo_hsize  in  WD_CONFIG_INFO  expected pixels per line; sampled at fsync.
- m_axis_dst_tdata  out  WD_VIDEO_DATA  stream data.
- m_axis_dst_tvalid  out  1  stream valid.
- m_axis_dst_tready  in  1  stream ready.
- m_axis_dst_tuser  out  1  start of frame (first pixel of frame).
- m_axis_dst_tlast  out  1  end of line.
- m_vinfo_dst_lines  out  WD_CONFIG_INFO  number of lines in the last completed frame.
- m_err_video_info  out  WD_ERR_INFO  sticky error vector; bit0 overflow, bit1 line-length mismatch, bit2 frame truncated, bit3 reserved (0).

Behaviour:
- Reset, asynchronous: all outputs 0, FIFO empty, FSM in IDLE, pending register invalid, counters 0.
- Pixel accept condition: vsync & hsync & psync while FSM is ACTIVE.
- FSM states:
  - IDLE: on fsync, latch hsize, set sof_flag, clear line counter, go ACTIVE.
  - ACTIVE: accepts pixels.
    - vsync falling: flush pending, publish the line count to m_vinfo_dst_lines, go IDLE.
    - Overflow: go DROP.
  - DROP: ignore all input until the next fsync, then behave as IDLE does on fsync.
- One-pixel holding register (pending) produces tlast:
  - An accepted pixel pushes the previous pending entry with last=0, then becomes the new pending entry.
  - hsync falling while pending is valid pushes pending with last=1, increments the line counter, and compares the line pixel count with the latched hsize; a mismatch sets err bit1.
  - The first pushed entry after fsync carries user=1; sof_flag clears on that push.
- FIFO entry is {user, last, data}. Write occurs on push. Read occurs when tvalid & tready. Outputs are driven from the FIFO head, so tvalid = !empty.
- Latency: input pixel to tvalid is 2 cycles with an empty FIFO (pending + FIFO register). Exception: the last pixel of a line appears 1 cycle after hsync falls.
- FIFO full on a push: the entry is discarded, err bit0 is set, FSM goes DROP.
  - Entries already in the FIFO still drain normally.
  - The dropped line gets no tlast; this is accepted.
- Simultaneous read and write when full: the write is allowed (no overflow).
- fsync while ACTIVE with pending valid: push pending with last=1, set err bit2, restart the frame (user=1 on the next push).
- The pixel counter and line counter saturate at all-ones; they do not wrap.
- tvalid, once asserted, holds with stable data/user/last until tready.
- Error bits clear only on reset.
- Reset mid-frame: the FIFO is emptied immediately and tvalid drops asynchronously.

Decomposition:
- Shared package (video_pkg): WD_* defaults, the error bit index constants (ERR_OVF=0, ERR_HLEN=1, ERR_TRUNC=2), and the FSM state enum {IDLE, ACTIVE, DROP}.
- One sub-module: video_sync_fifo. Parameterised width/depth, single clock, async active-low reset, full/empty flags, write-when-full allowed only with a simultaneous read.

Test Plan:
- Frame of 4 lines × 8 pixels, tready=1, hsize=8 → 32 beats; tuser only on beat 0; tlast on beats 7, 15, 23, 31; m_vinfo_dst_lines=4; errors stay 0.
- Same frame with hsize=6 → err bit1 set after line 0; data stream unchanged.
- tready=0 for the whole of line 0 with 20-pixel lines, depth 16 → err bit0 set, FSM enters DROP, 16 beats drain once tready=1, next frame's first beat has tuser=1 and is correct.
- tready toggling 1/0 each cycle, 2 lines × 5 pixels with psync every 3rd cycle → no overflow; 10 beats in order; tlast on beats 4 and 9.
- fsync mid-line after 3 pixels → the 3rd pixel is emitted with tlast=1; err bit2 set; next beat has tuser=1.
- Reset asserted while 5 entries are buffered → tvalid=0 immediately; after release, a clean 2×4 frame yields exactly 8 beats.
